// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, the byte-lane count, the IM depth and a lane helper.
package im_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int LANES    = 4;
    localparam int IM_DEPTH = 1024;

    // Byte lane taken by the n-th byte of a word.
    // Big-endian puts the first byte in lane 3 (bits 31:24).
    function automatic logic [1:0] lane_of(
        input logic [1:0] cnt,
        input logic       big_endian
    );
        return big_endian ? (2'(LANES - 1) - cnt) : cnt;
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream and IM write bus seen by the instruction-memory loader.
// master: loader side (drives byte_ready and IM write), slave: source/IM side.
interface im_loader_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_din;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_din
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_din
    );
endinterface

// File: rtl/im_word_pack.sv
// Assembles four accepted bytes into one 32-bit word with a lane counter.
// Ports: i_load_en (byte accepted), i_clear (restart word), i_byte, o_word, o_full.
module im_word_pack
    import im_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load_en,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [1:0]  w_lane;

    assign w_lane = lane_of(r_cnt, BIG_ENDIAN);

    // Asserted while the fourth byte of a word is being accepted.
    assign o_full = i_load_en && (r_cnt == 2'(LANES - 1));
    assign o_word = r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clear) begin
            r_cnt <= 2'd0;
        end else if (i_load_en) begin
            r_word[{w_lane, 3'b000} +: 8] <= i_byte;
            r_cnt <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Loads a program into IM from a byte stream, one 32-bit word per 4 bytes.
// Ports: clk, rst, i_start, i_len, bus (stream + IM write), o_busy, o_done, o_err.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int WORDS      = IM_DEPTH,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [ADDR_W:0] i_len,
    im_loader_if.master   bus,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_len;
    logic                r_done;
    logic                r_err;

    logic                w_len_ok;
    logic                w_clear;
    logic                w_reject;
    logic                w_last;
    logic                w_hs;
    logic                w_full;
    logic [31:0]         w_word;

    assign w_len_ok = (i_len != '0) &&
                      (32'(i_len) <= 32'(WORDS));
    assign w_last   = ({1'b0, r_addr} ==
                       (r_len - (ADDR_W + 1)'(1)));
    assign w_hs     = bus.byte_valid &&
                      (r_state == S_LOAD);

    im_word_pack #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_pack (
        .clk       (clk),
        .rst       (rst),
        .i_load_en (w_hs),
        .i_clear   (w_clear),
        .i_byte    (bus.byte_data),
        .o_word    (w_word),
        .o_full    (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_reject    = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    if (w_len_ok) begin
                        w_state_nxt = S_LOAD;
                        w_clear     = 1'b1;
                    end else begin
                        // A rejected start from DONE falls back to IDLE.
                        w_state_nxt = S_IDLE;
                        w_reject    = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (w_full) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt = w_last ? S_DONE : S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_clear) begin
            r_addr <= '0;
            r_len  <= i_len;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_reject) begin
            r_err  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_state == S_WRITE) begin
            // The last address holds so im_addr never passes len-1.
            if (w_last) r_done <= 1'b1;
            else        r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign bus.byte_ready = (r_state == S_LOAD);
    assign bus.im_we      = (r_state == S_WRITE);
    assign bus.im_addr    = r_addr;
    assign bus.im_din     = w_word;
    assign o_busy         = (r_state == S_LOAD) ||
                            (r_state == S_WRITE);
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: big- and little-endian instances share one stimulus.
// A word-level model predicts every output each cycle; literals pin key words.
module tb_im_loader;

    localparam int AW = 10;
    localparam int WD = 1024;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          valid;
    logic [7:0]    data;

    logic          busy_be, done_be, err_be;
    logic          busy_le, done_le, err_le;

    im_loader_if #(.ADDR_W(AW)) bus_be ();
    im_loader_if #(.ADDR_W(AW)) bus_le ();

    assign bus_be.byte_valid = valid;
    assign bus_be.byte_data  = data;
    assign bus_le.byte_valid = valid;
    assign bus_le.byte_data  = data;

    im_loader #(
        .ADDR_W(AW), .WORDS(WD), .BIG_ENDIAN(1'b1)
    ) u_be (
        .clk(clk), .rst(rst), .i_start(start), .i_len(len),
        .bus(bus_be), .o_busy(busy_be), .o_done(done_be),
        .o_err(err_be)
    );

    im_loader #(
        .ADDR_W(AW), .WORDS(WD), .BIG_ENDIAN(1'b0)
    ) u_le (
        .clk(clk), .rst(rst), .i_start(start), .i_len(len),
        .bus(bus_le), .o_busy(busy_le), .o_done(done_le),
        .o_err(err_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: one load = len words, each built from 4 stream bytes.
    int          m_active = 0;
    int          m_wr     = 0;
    int          m_done   = 0;
    int          m_err    = 0;
    int          m_idx    = 0;
    int          m_len    = 0;
    int          m_nb     = 0;
    logic [7:0]  m_b [4];
    logic [31:0] m_word_be;
    logic [31:0] m_word_le;

    logic [31:0] wr_be [8];
    logic [31:0] wr_le [8];
    int          nwr = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_wr = 0; m_done = 0;
            m_err = 0; m_idx = 0; m_nb = 0;
        end else if (m_wr != 0) begin
            m_wr = 0;
            if (m_idx == m_len - 1) begin
                m_active = 0;
                m_done   = 1;
            end else begin
                m_idx++;
            end
        end else if (m_active != 0) begin
            if (valid) begin
                m_b[m_nb] = data;
                m_nb++;
                if (m_nb == 4) begin
                    m_nb = 0;
                    m_wr = 1;
                    m_word_be = {m_b[0], m_b[1], m_b[2], m_b[3]};
                    m_word_le = {m_b[3], m_b[2], m_b[1], m_b[0]};
                end
            end
        end else if (start) begin
            if (int'(len) >= 1 && int'(len) <= WD) begin
                m_active = 1; m_len = int'(len);
                m_idx = 0; m_nb = 0;
                m_done = 0; m_err = 0;
            end else begin
                m_err  = 1;
                m_done = 0;
            end
        end
        #1;
        chk("be_ready", bus_be.byte_ready,
            (m_active != 0) && (m_wr == 0));
        chk("le_ready", bus_le.byte_ready,
            (m_active != 0) && (m_wr == 0));
        chk("be_we", bus_be.im_we, m_wr != 0);
        chk("le_we", bus_le.im_we, m_wr != 0);
        chk("be_busy", busy_be, m_active != 0);
        chk("le_busy", busy_le, m_active != 0);
        chk("be_done", done_be, m_done != 0);
        chk("le_done", done_le, m_done != 0);
        chk("be_err", err_be, m_err != 0);
        chk("le_err", err_le, m_err != 0);
        chk("be_addr", bus_be.im_addr, m_idx);
        chk("le_addr", bus_le.im_addr, m_idx);
        if (m_wr != 0) begin
            chk("be_din", bus_be.im_din, m_word_be);
            chk("le_din", bus_le.im_din, m_word_le);
        end
        if (bus_be.im_we && bus_be.im_addr < 8) begin
            wr_be[bus_be.im_addr[2:0]] = bus_be.im_din;
            nwr++;
        end
        if (bus_le.im_we && bus_le.im_addr < 8)
            wr_le[bus_le.im_addr[2:0]] = bus_le.im_din;
    end

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (AW + 1)'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        n     = 0;
        valid = 1'b1;
        data  = b;
        while (!bus_be.byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %h never taken", b);
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_be && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done_be, 1'b1);
    endtask

    logic [7:0] s1 [8];
    logic [7:0] s6 [12];

    initial begin
        s1 = '{8'h8C, 8'h01, 8'h00, 8'h04,
               8'hAC, 8'h02, 8'h00, 8'h08};
        for (int i = 0; i < 12; i++) s6[i] = 8'(8'h10 + i);
        rst = 1'b1; start = 1'b0; len = '0;
        valid = 1'b0; data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_din", bus_be.im_din, 32'h0);
        @(negedge clk);

        // Two words, back-to-back bytes.
        nwr = 0;
        do_start(2);
        for (int i = 0; i < 8; i++) send(s1[i], 0);
        wait_done();
        chk("t1_nwr", nwr, 2);
        chk("t1_be0", wr_be[0], 32'h8C010004);
        chk("t1_be1", wr_be[1], 32'hAC020008);
        chk("t1_le0", wr_le[0], 32'h0400018C);
        chk("t1_le1", wr_le[1], 32'h080002AC);
        chk("t1_busy", busy_be, 1'b0);

        // One word with 3-cycle gaps between bytes.
        nwr = 0;
        do_start(1);
        send(8'h11, 3); send(8'h22, 3);
        send(8'h33, 3); send(8'h44, 3);
        wait_done();
        repeat (3) @(negedge clk);
        chk("t2_nwr", nwr, 1);
        chk("t2_be0", wr_be[0], 32'h11223344);
        chk("t2_le0", wr_le[0], 32'h44332211);

        // Rejected lengths, stray valid while idle.
        nwr = 0;
        do_start(0);
        @(negedge clk);
        chk("t3_err0", err_be, 1'b1);
        valid = 1'b1; data = 8'h55;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        do_start(WD + 1);
        @(negedge clk);
        chk("t3_err1", err_be, 1'b1);
        chk("t3_nwr", nwr, 0);
        do_start(1);
        chk("t3_clr", err_be, 1'b0);
        send(8'h01, 0); send(8'h02, 0);
        send(8'h03, 0); send(8'h04, 0);
        wait_done();
        chk("t3_be0", wr_be[0], 32'h01020304);

        // Reset after 6 of 8 bytes.
        nwr = 0;
        wr_be[1] = 32'h0;
        do_start(2);
        for (int i = 0; i < 6; i++) send(s1[i], 0);
        rst = 1'b1;
        #1;
        chk("t4_busy", busy_be, 1'b0);
        chk("t4_rdy", bus_be.byte_ready, 1'b0);
        chk("t4_we", bus_be.im_we, 1'b0);
        chk("t4_addr", bus_be.im_addr, 0);
        chk("t4_din", bus_le.im_din, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_nwr", nwr, 1);
        chk("t4_nowr1", wr_be[1], 32'h0);
        nwr = 0;
        do_start(1);
        send(8'hDE, 0); send(8'hAD, 0);
        send(8'hBE, 0); send(8'hEF, 0);
        wait_done();
        chk("t4_nwr2", nwr, 1);
        chk("t4_be0", wr_be[0], 32'hDEADBEEF);

        // start during LOAD is ignored.
        nwr = 0;
        do_start(3);
        for (int i = 0; i < 4; i++) send(s6[i], 0);
        do_start(1);
        for (int i = 4; i < 12; i++) send(s6[i], 0);
        wait_done();
        repeat (2) @(negedge clk);
        chk("t5_nwr", nwr, 3);
        chk("t5_be2", wr_be[2], 32'h18191A1B);
        chk("t5_le2", wr_le[2], 32'h1B1A1918);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
